// File: rtl/match_len_responder_pkg.sv
// Shared widths, window constants, FSM states and the limit-window helper
// for match_len_responder (optional MATCH_LEN_RESP_LIMIT_EN build).
package match_len_responder_pkg;

    localparam int ADDR_WIDTH         = 16;
    localparam int MATCH_LEN_WIDTH    = 8;
    localparam int LAZY_MATCH_LEN     = 4;
    localparam int MATCH_WINDOW_BYTES = 16;
    localparam int MATCH_MAX_LEN      = 255;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_RD_HEAD   = 3'd1,
        S_WAIT_HEAD = 3'd2,
        S_RD_HIST   = 3'd3,
        S_WAIT_HIST = 3'd4,
        S_CMP       = 3'd5,
        S_RESP      = 3'd6
    } state_e;

    // A head byte is usable when limit is 1..2**(AW-1) bytes ahead of it.
    function automatic logic byte_in_limit(
        input logic [ADDR_WIDTH-1:0] limit,
        input logic [ADDR_WIDTH-1:0] addr
    );
        logic [ADDR_WIDTH-1:0] d;
        d = limit - addr;
        return (d != '0) &&
               (!d[ADDR_WIDTH-1] || (d[ADDR_WIDTH-2:0] == '0));
    endfunction

endpackage

// File: rtl/match_len_responder_eq.sv
// match_eq_counter: leading-equal byte count of two windows, priority
// encoded over the stop vector (mismatch, or limit miss when enabled).
module match_eq_counter
    import match_len_responder_pkg::*;
#(
    parameter int W = MATCH_WINDOW_BYTES
) (
    input  logic [W*8-1:0]          a_i,
    input  logic [W*8-1:0]          b_i,
`ifdef MATCH_LEN_RESP_LIMIT_EN
    input  logic [ADDR_WIDTH-1:0]   base_i,
    input  logic [ADDR_WIDTH-1:0]   limit_i,
`endif
    output logic [$clog2(W):0]      eq_o
);

    localparam int CW = $clog2(W) + 1;

    logic [W-1:0] stop;

    always_comb begin
        stop = '0;
        for (int i = 0; i < W; i++) begin
            stop[i] = a_i[8*i +: 8] != b_i[8*i +: 8];
`ifdef MATCH_LEN_RESP_LIMIT_EN
            stop[i] = stop[i] |
                !byte_in_limit(limit_i, base_i + ADDR_WIDTH'(i));
`endif
        end
    end

    always_comb begin
        eq_o = CW'(W);
        for (int i = W - 1; i >= 0; i--) begin
            if (stop[i]) begin
                eq_o = CW'(i);
            end
        end
    end

endmodule

// File: rtl/match_len_responder.sv
// Match-length responder: fetches head/history windows, counts equal bytes
// and returns the saturated length with the request tag.
// Optional head-limit masking via `MATCH_LEN_RESP_LIMIT_EN.
module match_len_responder
    import match_len_responder_pkg::*;
#(
    parameter int WINDOW_BYTES  = MATCH_WINDOW_BYTES,
    parameter int MAX_MATCH_LEN = MATCH_MAX_LEN
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       match_req_valid,
    input  logic [ADDR_WIDTH-1:0]      match_req_head_addr,
    input  logic [ADDR_WIDTH-1:0]      match_req_history_addr,
    input  logic [LAZY_MATCH_LEN-1:0]  match_req_tag,
    output logic                       match_req_ready,
    output logic                       match_resp_valid,
    output logic [MATCH_LEN_WIDTH-1:0] match_resp_len,
    output logic [LAZY_MATCH_LEN-1:0]  match_resp_tag,
    input  logic                       match_resp_ready,
    output logic                       mem_req_valid,
    output logic [ADDR_WIDTH-1:0]      mem_req_addr,
    input  logic                       mem_req_ready,
    input  logic                       mem_resp_valid,
    input  logic [WINDOW_BYTES*8-1:0]  mem_resp_data,
`ifdef MATCH_LEN_RESP_LIMIT_EN
    input  logic [ADDR_WIDTH-1:0]      limit_addr,
`endif
    output logic                       mem_resp_ready
);

    localparam int EW = $clog2(WINDOW_BYTES) + 1;
    localparam int SW = MATCH_LEN_WIDTH + 1;

    localparam logic [ADDR_WIDTH-1:0] STEP = ADDR_WIDTH'(WINDOW_BYTES);
    localparam logic [SW-1:0] MAX_S = SW'(MAX_MATCH_LEN);
    localparam logic [EW-1:0] FULL  = EW'(WINDOW_BYTES);

    state_e                     state_q;
    logic [ADDR_WIDTH-1:0]      head_q;
    logic [ADDR_WIDTH-1:0]      hist_q;
    logic [ADDR_WIDTH-1:0]      addr_q;
    logic [LAZY_MATCH_LEN-1:0]  tag_q;
    logic [MATCH_LEN_WIDTH-1:0] len_q;
    logic [WINDOW_BYTES*8-1:0]  head_data_q;
    logic [WINDOW_BYTES*8-1:0]  hist_data_q;
    logic                       req_rdy_q;
    logic                       resp_vld_q;
    logic                       mreq_vld_q;
    logic                       mresp_rdy_q;

    logic [EW-1:0]              eq;
    logic [SW-1:0]              sum_d;
    logic [MATCH_LEN_WIDTH-1:0] len_d;
    logic                       cont_d;

    match_eq_counter #(
        .W       (WINDOW_BYTES)
    ) u_eq (
        .a_i     (head_data_q),
        .b_i     (hist_data_q),
`ifdef MATCH_LEN_RESP_LIMIT_EN
        .base_i  (head_q),
        .limit_i (limit_addr),
`endif
        .eq_o    (eq)
    );

    // Sum is one bit wider so the saturation test cannot wrap.
    always_comb begin
        sum_d  = {1'b0, len_q} + SW'(eq);
        len_d  = (sum_d > MAX_S) ? MAX_S[MATCH_LEN_WIDTH-1:0]
                                 : sum_d[MATCH_LEN_WIDTH-1:0];
        cont_d = (eq == FULL) && (sum_d < MAX_S);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            head_q      <= '0;
            hist_q      <= '0;
            addr_q      <= '0;
            tag_q       <= '0;
            len_q       <= '0;
            head_data_q <= '0;
            hist_data_q <= '0;
            req_rdy_q   <= 1'b1;
            resp_vld_q  <= 1'b0;
            mreq_vld_q  <= 1'b0;
            mresp_rdy_q <= 1'b0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (match_req_valid) begin
                        head_q     <= match_req_head_addr;
                        hist_q     <= match_req_history_addr;
                        tag_q      <= match_req_tag;
                        len_q      <= '0;
                        addr_q     <= match_req_head_addr;
                        req_rdy_q  <= 1'b0;
                        mreq_vld_q <= 1'b1;
                        state_q    <= S_RD_HEAD;
                    end
                end
                S_RD_HEAD: begin
                    if (mem_req_ready) begin
                        mreq_vld_q  <= 1'b0;
                        mresp_rdy_q <= 1'b1;
                        state_q     <= S_WAIT_HEAD;
                    end
                end
                S_WAIT_HEAD: begin
                    if (mem_resp_valid) begin
                        head_data_q <= mem_resp_data;
                        mresp_rdy_q <= 1'b0;
                        mreq_vld_q  <= 1'b1;
                        addr_q      <= hist_q;
                        state_q     <= S_RD_HIST;
                    end
                end
                S_RD_HIST: begin
                    if (mem_req_ready) begin
                        mreq_vld_q  <= 1'b0;
                        mresp_rdy_q <= 1'b1;
                        state_q     <= S_WAIT_HIST;
                    end
                end
                S_WAIT_HIST: begin
                    if (mem_resp_valid) begin
                        hist_data_q <= mem_resp_data;
                        mresp_rdy_q <= 1'b0;
                        state_q     <= S_CMP;
                    end
                end
                S_CMP: begin
                    len_q <= len_d;
                    if (cont_d) begin
                        head_q     <= head_q + STEP;
                        hist_q     <= hist_q + STEP;
                        addr_q     <= head_q + STEP;
                        mreq_vld_q <= 1'b1;
                        state_q    <= S_RD_HEAD;
                    end else begin
                        resp_vld_q <= 1'b1;
                        state_q    <= S_RESP;
                    end
                end
                S_RESP: begin
                    if (match_resp_ready) begin
                        resp_vld_q <= 1'b0;
                        req_rdy_q  <= 1'b1;
                        state_q    <= S_IDLE;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign match_req_ready  = req_rdy_q;
    assign match_resp_valid = resp_vld_q;
    assign match_resp_len   = len_q;
    assign match_resp_tag   = tag_q;
    assign mem_req_valid    = mreq_vld_q;
    assign mem_req_addr     = addr_q;
    assign mem_resp_ready   = mresp_rdy_q;

endmodule

// File: tb/tb_match_len_responder.sv
// Directed bench for match_len_responder: byte-level reference model over a
// flat memory image, per-cycle response checks and read-address tracking.
module tb_match_len_responder;
    import match_len_responder_pkg::*;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         match_req_valid;
    logic [15:0]  match_req_head_addr;
    logic [15:0]  match_req_history_addr;
    logic [3:0]   match_req_tag;
    logic         match_req_ready;
    logic         match_resp_valid;
    logic [7:0]   match_resp_len;
    logic [3:0]   match_resp_tag;
    logic         match_resp_ready;
    logic         mem_req_valid;
    logic [15:0]  mem_req_addr;
    logic         mem_req_ready;
    logic         mem_resp_valid;
    logic [127:0] mem_resp_data;
    logic         mem_resp_ready;
    logic [15:0]  lim_v;
`ifdef MATCH_LEN_RESP_LIMIT_EN
    logic [15:0]  limit_addr;
    assign limit_addr = lim_v;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0]  mem [0:65535];
    logic [15:0] pend[$];
    logic [15:0] rd_log[$];
    bit          rand_stall = 0;
    bit          hold_hist  = 0;
    bit          busy       = 0;
    int          exp_len;
    logic [3:0]  exp_tag;

    always #5 clk = ~clk;

    match_len_responder dut (
        .clk                    (clk),
        .rst_n                  (rst_n),
        .match_req_valid        (match_req_valid),
        .match_req_head_addr    (match_req_head_addr),
        .match_req_history_addr (match_req_history_addr),
        .match_req_tag          (match_req_tag),
        .match_req_ready        (match_req_ready),
        .match_resp_valid       (match_resp_valid),
        .match_resp_len         (match_resp_len),
        .match_resp_tag         (match_resp_tag),
        .match_resp_ready       (match_resp_ready),
        .mem_req_valid          (mem_req_valid),
        .mem_req_addr           (mem_req_addr),
        .mem_req_ready          (mem_req_ready),
        .mem_resp_valid         (mem_resp_valid),
        .mem_resp_data          (mem_resp_data),
`ifdef MATCH_LEN_RESP_LIMIT_EN
        .limit_addr             (limit_addr),
`endif
        .mem_resp_ready         (mem_resp_ready)
    );

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [127:0] window(input logic [15:0] a);
        logic [127:0] d;
        logic [15:0]  x;
        for (int i = 0; i < 16; i++) begin
            x = a + 16'(i);
            d[8*i +: 8] = mem[x];
        end
        return d;
    endfunction

    // Reference: first byte offset where data differs or limit excludes it,
    // saturated at 255.
    function automatic int model_len(input logic [15:0] head,
                                     input logic [15:0] hist,
                                     input logic [15:0] lim);
        int n;
        logic [15:0] a, b;
        int d;
        n = 0;
        while (n < 256) begin
            a = head + 16'(n);
            b = hist + 16'(n);
            if (mem[a] != mem[b]) break;
`ifdef MATCH_LEN_RESP_LIMIT_EN
            d = int'(lim - a);
            if (d < 1 || d > 32768) break;
`else
            d = int'(lim);
`endif
            n++;
        end
        return (n > 255) ? 255 : n;
    endfunction

    task automatic set_region(input logic [15:0] head,
                              input logic [15:0] hist,
                              input int n, input int mm);
        logic [15:0] a, b;
        logic [7:0]  v;
        for (int k = 0; k < n; k++) begin
            a = head + 16'(k);
            b = hist + 16'(k);
            v = 8'($urandom);
            mem[a] = v;
            mem[b] = v;
        end
        if (mm >= 0) begin
            a = head + 16'(mm);
            b = hist + 16'(mm);
            mem[b] = mem[a] ^ 8'h5A;
        end
    endtask

    // Memory: in-order, zero-wait unless stalls are enabled.
    always @(negedge clk) begin
        if (!rst_n) begin
            pend.delete();
            mem_resp_valid = 1'b0;
            mem_req_ready  = 1'b0;
            mem_resp_data  = '0;
        end else begin
            mem_req_ready = rand_stall ? ($urandom_range(0, 2) != 0) : 1'b1;
            if (pend.size() > 0 && !(hold_hist && rd_log.size() >= 2) &&
                !(rand_stall && $urandom_range(0, 2) == 0)) begin
                mem_resp_valid = 1'b1;
                mem_resp_data  = window(pend[0]);
            end else begin
                mem_resp_valid = 1'b0;
            end
            if (mem_req_valid && mem_req_ready) begin
                pend.push_back(mem_req_addr);
                rd_log.push_back(mem_req_addr);
            end
            if (mem_resp_valid && mem_resp_ready) pend.pop_front();
        end
    end

    // Every busy cycle: no new request accepted; response held at model value.
    always @(negedge clk) begin
        if (rst_n && busy) begin
            n_tests++;
            if (match_req_ready) begin
                n_fail++;
                $display("FAIL req_ready_busy: got 1 expected 0");
            end
            if (match_resp_valid) begin
                n_tests++;
                if (int'(match_resp_len) != exp_len ||
                    match_resp_tag != exp_tag) begin
                    n_fail++;
                    $display("FAIL resp: got len %0d tag %h expected len %0d tag %h",
                             match_resp_len, match_resp_tag, exp_len, exp_tag);
                end
            end
        end
    end

    task automatic run_job(input logic [15:0] head, input logic [15:0] hist,
                           input logic [3:0] tag, input logic [15:0] lim,
                           input int lit_len, input int hold,
                           input bit chk_lat);
        int mlen, nw, cyc;
        bit ok;
        logic [15:0] ea;
        mlen = model_len(head, hist, lim);
        nw   = mlen / 16 + 1;
        if (lit_len >= 0) check("model_len", mlen, lit_len);
        exp_len = mlen;
        exp_tag = tag;
        rd_log.delete();
        @(negedge clk);
        lim_v                  = lim;
        match_req_valid        = 1'b1;
        match_req_head_addr    = head;
        match_req_history_addr = hist;
        match_req_tag          = tag;
        cyc = 0;
        while (!match_req_ready && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        if (cyc >= 100) check("req_accept_timeout", 1, 0);
        @(negedge clk);
        match_req_valid = 1'b0;
        busy = 1;
        cyc = 1;
        while (!match_resp_valid && cyc < 3000) begin
            @(negedge clk);
            cyc++;
        end
        if (!match_resp_valid) check("resp_timeout", 1, 0);
        else if (chk_lat) check("latency", cyc, 6 + 5 * (nw - 1));
        repeat (hold) @(negedge clk);
        match_resp_ready = 1'b1;
        busy = 0;
        @(negedge clk);
        match_resp_ready = 1'b0;
        check("resp_released", int'(match_resp_valid), 0);
        check("req_ready_idle", int'(match_req_ready), 1);
        ok = (rd_log.size() == 2 * nw);
        for (int w = 0; ok && w < nw; w++) begin
            ea = head + 16'(16 * w);
            if (rd_log[2*w] != ea) ok = 0;
            ea = hist + 16'(16 * w);
            if (rd_log[2*w+1] != ea) ok = 0;
        end
        check("rd_addrs", int'(ok), 1);
        check("rd_count", rd_log.size(), 2 * nw);
    endtask

    task automatic check_reset_outputs(input string tagname);
        check({tagname, "_req_ready"},  int'(match_req_ready), 1);
        check({tagname, "_resp_valid"}, int'(match_resp_valid), 0);
        check({tagname, "_resp_len"},   int'(match_resp_len), 0);
        check({tagname, "_resp_tag"},   int'(match_resp_tag), 0);
        check({tagname, "_mreq_valid"}, int'(mem_req_valid), 0);
        check({tagname, "_mreq_addr"},  int'(mem_req_addr), 0);
        check({tagname, "_mresp_rdy"},  int'(mem_resp_ready), 0);
    endtask

    initial begin
        int cyc;
        for (int i = 0; i < 65536; i++) mem[i] = 8'(i * 7 + 3);
        rst_n                  = 1'b0;
        match_req_valid        = 1'b0;
        match_req_head_addr    = '0;
        match_req_history_addr = '0;
        match_req_tag          = '0;
        match_resp_ready       = 1'b0;
        lim_v                  = '0;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst_n = 1'b1;

        set_region(16'h0100, 16'h0000, 48, 5);
        run_job(16'h0100, 16'h0000, 4'b0001, 16'h8100, 5, 0, 1);

        set_region(16'h0400, 16'h0800, 64, 40);
        run_job(16'h0400, 16'h0800, 4'b0010, 16'h8400, 40, 0, 1);

        set_region(16'h1000, 16'h3000, 300, -1);
        run_job(16'h1000, 16'h3000, 4'b0100, 16'h9000, 255, 0, 1);

        for (int k = 0; k < 20; k++) mem[16'h4FFF + k] = 8'hAA;
        mem[16'h5013] = 8'h55;
        run_job(16'h5000, 16'h4FFF, 4'b1000, 16'hD000, 19, 0, 1);

        rand_stall = 1;
        set_region(16'h6000, 16'h6800, 64, 33);
        run_job(16'h6000, 16'h6800, 4'b0010, 16'hE000, 33, 10, 0);
        rand_stall = 0;

        set_region(16'hFFF8, 16'h7FF8, 40, 20);
        run_job(16'hFFF8, 16'h7FF8, 4'b0001, 16'h7FF8, 20, 2, 1);

        // Abort a job while the history read is outstanding.
        hold_hist = 1;
        rd_log.delete();
        @(negedge clk);
        match_req_valid        = 1'b1;
        match_req_head_addr    = 16'h9000;
        match_req_history_addr = 16'hA000;
        match_req_tag          = 4'b0100;
        lim_v                  = 16'h1000;
        @(negedge clk);
        match_req_valid = 1'b0;
        cyc = 0;
        while (rd_log.size() < 2 && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        @(negedge clk);
        check("wait_hist_mresp_rdy", int'(mem_resp_ready), 1);
        #2 rst_n = 1'b0;
        #1 check_reset_outputs("midreset");
        @(negedge clk);
        hold_hist = 0;
        @(negedge clk);
        rst_n = 1'b1;

`ifdef MATCH_LEN_RESP_LIMIT_EN
        set_region(16'h9000, 16'hA000, 64, -1);
`else
        set_region(16'h9000, 16'hA000, 64, 3);
`endif
        run_job(16'h9000, 16'hA000, 4'b0100, 16'h9003, 3, 0, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
